// File: rtl/scene_fader.sv
// Scene source select plus menu->game handover (fade-out, black hold, fade-in).
// Optional skip-to-game feature is enabled by defining SCENE_FADE_SKIP_EN.
module scene_fader #(
  parameter int COLR_BITS    = 8,
  parameter int FADE_STEP    = 8,
  parameter int BLACK_FRAMES = 30
) (
  input  logic                 i_clk_pix,
  input  logic                 i_rst_n,
  input  logic                 i_frame,
  input  logic                 i_main_start,
  input  logic                 i_game_ready,
  input  logic                 i_skip,
  input  logic [COLR_BITS-1:0] i_menu_r,
  input  logic [COLR_BITS-1:0] i_menu_g,
  input  logic [COLR_BITS-1:0] i_menu_b,
  input  logic [COLR_BITS-1:0] i_game_r,
  input  logic [COLR_BITS-1:0] i_game_g,
  input  logic [COLR_BITS-1:0] i_game_b,
  output logic                 o_game_en,
  output logic                 o_busy,
  output logic [COLR_BITS-1:0] o_red,
  output logic [COLR_BITS-1:0] o_green,
  output logic [COLR_BITS-1:0] o_blue
);

  typedef enum logic [2:0] {
    ST_MENU     = 3'd0,
    ST_FADE_OUT = 3'd1,
    ST_BLACK    = 3'd2,
    ST_FADE_IN  = 3'd3,
    ST_GAME     = 3'd4
  } state_e;

  localparam int          PROD_W  = COLR_BITS + 9;
  localparam logic [7:0]  STEP    = 8'(FADE_STEP);
  localparam logic [7:0]  FULL    = 8'd255;
  localparam logic [15:0] HOLD    = 16'(BLACK_FRAMES);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_e               state_q, state_d;
  logic [7:0]           level_q, level_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 start_q;
  logic                 start_rise_s;
  logic                 skip_take_s;
  logic [7:0]           level_dn_s, level_up_s;
  logic [15:0]          frame_cnt_inc_s;
  logic [COLR_BITS-1:0] src_r_s, src_g_s, src_b_s;
  logic [COLR_BITS-1:0] pix_r_s, pix_g_s, pix_b_s;
  logic                 game_en_q, busy_q;
  logic [COLR_BITS-1:0] red_q, green_q, blue_q;

  // (level+1) makes level 255 an exact pass-through of the colour
  function automatic logic [COLR_BITS-1:0] fade_scale(input logic [COLR_BITS-1:0] c,
                                                      input logic [7:0]           lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'({1'b0, lvl} + 9'd1);
    return COLR_BITS'(prod >> 4'd8);
  endfunction

  assign start_rise_s    = i_main_start & ~start_q;
  assign level_dn_s      = (level_q > STEP) ? (level_q - STEP) : 8'd0;
  assign level_up_s      = (level_q < (FULL - STEP)) ? (level_q + STEP) : FULL;
  assign frame_cnt_inc_s = (frame_cnt_q == CNT_MAX) ? CNT_MAX : (frame_cnt_q + 16'd1);

`ifdef SCENE_FADE_SKIP_EN
  logic skip_q;

  // Skip edge detector
  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skip_q <= 1'b0;
    end else begin
      skip_q <= i_skip;
    end
  end

  assign skip_take_s = i_skip & ~skip_q &
                       ((state_q == ST_FADE_OUT) | (state_q == ST_BLACK) | (state_q == ST_FADE_IN));
`else
  logic skip_unused_s;
  assign skip_unused_s = i_skip;
  assign skip_take_s   = 1'b0;
`endif

  // State, brightness and black-hold counter registers
  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_MENU;
      level_q     <= FULL;
      frame_cnt_q <= 16'd0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      start_q     <= i_main_start;
    end
  end

  // Next-state: only MENU exit and skip ignore the frame strobe
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    if (skip_take_s) begin
      if (i_game_ready) begin
        state_d = ST_GAME;
        level_d = FULL;
      end else begin
        state_d     = ST_BLACK;
        level_d     = 8'd0;
        frame_cnt_d = HOLD;
      end
    end else begin
      case (state_q)
        ST_MENU: begin
          level_d = FULL;
          if (start_rise_s) begin
            state_d = ST_FADE_OUT;
          end else begin
            state_d = ST_MENU;
          end
        end
        ST_FADE_OUT: begin
          if (i_frame) begin
            level_d = level_dn_s;
            if (level_dn_s == 8'd0) begin
              state_d     = ST_BLACK;
              frame_cnt_d = 16'd0;
            end else begin
              state_d = ST_FADE_OUT;
            end
          end else begin
            level_d = level_q;
          end
        end
        ST_BLACK: begin
          level_d = 8'd0;
          if (i_frame) begin
            frame_cnt_d = frame_cnt_inc_s;
            if ((frame_cnt_q >= HOLD) && i_game_ready) begin
              state_d = ST_FADE_IN;
            end else begin
              state_d = ST_BLACK;
            end
          end else begin
            frame_cnt_d = frame_cnt_q;
          end
        end
        ST_FADE_IN: begin
          if (i_frame) begin
            level_d = level_up_s;
            if (level_up_s == FULL) begin
              state_d = ST_GAME;
            end else begin
              state_d = ST_FADE_IN;
            end
          end else begin
            level_d = level_q;
          end
        end
        ST_GAME: begin
          state_d = ST_GAME;
          level_d = FULL;
        end
        default: begin
          state_d     = ST_MENU;
          level_d     = FULL;
          frame_cnt_d = 16'd0;
        end
      endcase
    end
  end

  // Source select and brightness scaling
  always_comb begin
    if ((state_q == ST_FADE_IN) || (state_q == ST_GAME)) begin
      src_r_s = i_game_r;
      src_g_s = i_game_g;
      src_b_s = i_game_b;
    end else begin
      src_r_s = i_menu_r;
      src_g_s = i_menu_g;
      src_b_s = i_menu_b;
    end
    if (state_q == ST_BLACK) begin
      pix_r_s = {COLR_BITS{1'b0}};
      pix_g_s = {COLR_BITS{1'b0}};
      pix_b_s = {COLR_BITS{1'b0}};
    end else begin
      pix_r_s = fade_scale(src_r_s, level_q);
      pix_g_s = fade_scale(src_g_s, level_q);
      pix_b_s = fade_scale(src_b_s, level_q);
    end
  end

  // Output registers; busy follows the state being entered
  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      red_q     <= {COLR_BITS{1'b0}};
      green_q   <= {COLR_BITS{1'b0}};
      blue_q    <= {COLR_BITS{1'b0}};
      game_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      red_q     <= pix_r_s;
      green_q   <= pix_g_s;
      blue_q    <= pix_b_s;
      game_en_q <= (state_q == ST_BLACK) || (state_q == ST_FADE_IN) || (state_q == ST_GAME);
      busy_q    <= (state_d == ST_FADE_OUT) || (state_d == ST_BLACK) || (state_d == ST_FADE_IN);
    end
  end

  assign o_red     = red_q;
  assign o_green   = green_q;
  assign o_blue    = blue_q;
  assign o_game_en = game_en_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_scene_fader.sv
// Bench for scene_fader: two instances (step 8 / hold 30 and step 100 / hold 2)
// against a frame-level behavioural model, plus directed tables and corner sequences.
module tb_scene_fader;

  localparam int M_MENU = 0, M_FOUT = 1, M_BLACK = 2, M_FIN = 3, M_GAME = 4;

  typedef struct {
    int mode; int lvl; int fcnt;
    bit sp; bit kp; bit en; bit busy;
    int r; int g; int b;
  } mdl_t;

  typedef struct {
    int frames; int r; int g; int b; int er; int eg; int eb; int ebr;
  } vec_t;

  logic       clk, rst_n, frame, start, ready, skip;
  logic [7:0] menu_r, menu_g, menu_b, game_r, game_g, game_b;
  logic       a_en, a_busy, b_en, b_busy;
  logic [7:0] a_red, a_green, a_blue, b_red, b_green, b_blue;

  int   checks = 0;
  int   errors = 0;
  bit   rand_pix;
  mdl_t ma, mdb;
  vec_t tbl[5];

  scene_fader dut_a (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_frame(frame), .i_main_start(start),
    .i_game_ready(ready), .i_skip(skip),
    .i_menu_r(menu_r), .i_menu_g(menu_g), .i_menu_b(menu_b),
    .i_game_r(game_r), .i_game_g(game_g), .i_game_b(game_b),
    .o_game_en(a_en), .o_busy(a_busy), .o_red(a_red), .o_green(a_green), .o_blue(a_blue)
  );

  scene_fader #(.FADE_STEP(100), .BLACK_FRAMES(2)) dut_b (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_frame(frame), .i_main_start(start),
    .i_game_ready(ready), .i_skip(skip),
    .i_menu_r(menu_r), .i_menu_g(menu_g), .i_menu_b(menu_b),
    .i_game_r(game_r), .i_game_g(game_g), .i_game_b(game_b),
    .o_game_en(b_en), .o_busy(b_busy), .o_red(b_red), .o_green(b_green), .o_blue(b_blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mreset();
    mdl_t m;
    m.mode = M_MENU; m.lvl = 255; m.fcnt = 0;
    m.sp = 1'b0; m.kp = 1'b0; m.en = 1'b0; m.busy = 1'b0;
    m.r = 0; m.g = 0; m.b = 0;
    return m;
  endfunction

  // One pixel clock of the handover, evaluated from the current inputs.
  function automatic mdl_t mstep(mdl_t m, int step, int hold);
    mdl_t n;
    bit   rise;
    int   sr, sg, sb;
    if (!rst_n) return mreset();
    n = m;
    rise = start && !m.sp;
    n.sp = start;
    n.kp = skip;
    n.en = (m.mode >= M_BLACK);
    if (m.mode <= M_FOUT) begin
      sr = int'(menu_r); sg = int'(menu_g); sb = int'(menu_b);
    end else begin
      sr = int'(game_r); sg = int'(game_g); sb = int'(game_b);
    end
    if (m.mode == M_BLACK) begin
      n.r = 0; n.g = 0; n.b = 0;
    end else begin
      n.r = sr * (m.lvl + 1) / 256;
      n.g = sg * (m.lvl + 1) / 256;
      n.b = sb * (m.lvl + 1) / 256;
    end
    case (m.mode)
      M_MENU: if (rise) n.mode = M_FOUT;
      M_FOUT: if (frame) begin
        n.lvl = (m.lvl - step < 0) ? 0 : m.lvl - step;
        if (n.lvl == 0) begin n.mode = M_BLACK; n.fcnt = 0; end
      end
      M_BLACK: if (frame) begin
        if (m.fcnt >= hold && ready) n.mode = M_FIN;
        n.fcnt = (m.fcnt >= 65535) ? 65535 : m.fcnt + 1;
      end
      M_FIN: if (frame) begin
        n.lvl = (m.lvl + step > 255) ? 255 : m.lvl + step;
        if (n.lvl == 255) n.mode = M_GAME;
      end
      default: n.lvl = 255;
    endcase
`ifdef SCENE_FADE_SKIP_EN
    if (skip && !m.kp && m.mode >= M_FOUT && m.mode <= M_FIN) begin
      if (ready) begin n.mode = M_GAME; n.lvl = 255; end
      else begin n.mode = M_BLACK; n.lvl = 0; n.fcnt = hold; end
    end
`endif
    n.busy = (n.mode >= M_FOUT) && (n.mode <= M_FIN);
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("a_red",   int'(a_red),   ma.r);
    chk("a_green", int'(a_green), ma.g);
    chk("a_blue",  int'(a_blue),  ma.b);
    chk("a_en",    int'(a_en),    int'(ma.en));
    chk("a_busy",  int'(a_busy),  int'(ma.busy));
    chk("b_red",   int'(b_red),   mdb.r);
    chk("b_green", int'(b_green), mdb.g);
    chk("b_blue",  int'(b_blue),  mdb.b);
    chk("b_en",    int'(b_en),    int'(mdb.en));
    chk("b_busy",  int'(b_busy),  int'(mdb.busy));
  endtask

  task automatic tick();
    if (rand_pix) begin
      menu_r = 8'($urandom); menu_g = 8'($urandom); menu_b = 8'($urandom);
      game_r = 8'($urandom); game_g = 8'($urandom); game_b = 8'($urandom);
    end
    @(posedge clk);
    ma  = mstep(ma, 8, 30);
    mdb = mstep(mdb, 100, 2);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic frame_pulse();
    frame = 1'b1; tick();
    frame = 1'b0; tick(); tick();
  endtask

  initial begin
    int done;
    int fin_exp[3];
    tbl[0] = '{1,  'h80, 'h40, 'hFF, 'h7C, 'h3E, 'hF7, 'h4E};
    tbl[1] = '{2,  'h80, 'h10, 'hC8, 'h78, 'h0F, 'hBB, 'h1C};
    tbl[2] = '{16, 'hFF, 'h01, 'h64, 'h7F, 'h00, 'h32, 'h00};
    tbl[3] = '{31, 'h80, 'hFF, 'h1F, 'h04, 'h07, 'h00, 'h00};
    tbl[4] = '{32, 'hAA, 'hFF, 'h55, 'h00, 'h00, 'h00, 'h00};
    fin_exp[0] = 100; fin_exp[1] = 200; fin_exp[2] = 255;

    rst_n = 1'b0; frame = 1'b0; start = 1'b0; ready = 1'b0; skip = 1'b0;
    menu_r = 8'h80; menu_g = 8'h40; menu_b = 8'hFF;
    game_r = 8'h00; game_g = 8'h00; game_b = 8'h00;
    rand_pix = 1'b0;
    ma = mreset(); mdb = mreset();
    repeat (3) @(negedge clk);
    cmp_all();

    // Menu passes through at full brightness
    rst_n = 1'b1;
    tick();
    chk("menu_red", int'(a_red), 'h80);
    chk("menu_green", int'(a_green), 'h40);
    chk("menu_blue", int'(a_blue), 'hFF);

    // Fade-out table (both instances fade in parallel)
    start = 1'b1;
    rand_pix = 1'b1;
    tick();
    done = 0;
    for (int i = 0; i < 5; i++) begin
      while (done < tbl[i].frames) begin
        frame_pulse();
        done++;
      end
      rand_pix = 1'b0;
      menu_r = 8'(tbl[i].r); menu_g = 8'(tbl[i].g); menu_b = 8'(tbl[i].b);
      tick();
      chk("tbl_a_red",   int'(a_red),   tbl[i].er);
      chk("tbl_a_green", int'(a_green), tbl[i].eg);
      chk("tbl_a_blue",  int'(a_blue),  tbl[i].eb);
      chk("tbl_b_red",   int'(b_red),   tbl[i].ebr);
      rand_pix = 1'b1;
    end

    // Black holds while the game is not ready
    repeat (100) frame_pulse();
    chk("hold_a_busy", int'(a_busy), 1);
    chk("hold_a_en", int'(a_en), 1);
    chk("hold_a_red", int'(a_red), 0);
    chk("hold_b_busy", int'(b_busy), 1);

    // Ready: fade-in starts on the next frame; step 100 saturates at 255
    ready = 1'b1;
    frame_pulse();
    rand_pix = 1'b0;
    game_r = 8'hFF; game_g = 8'hFF; game_b = 8'hFF;
    tick();
    chk("fin_b_red_l0", int'(b_red), 0);
    for (int i = 0; i < 3; i++) begin
      frame = 1'b1; tick();
      frame = 1'b0; tick();
      chk("fin_b_red", int'(b_red), fin_exp[i]);
    end
    chk("game_b_busy", int'(b_busy), 0);
    chk("game_b_en", int'(b_en), 1);
    chk("game_b_blue", int'(b_blue), 'hFF);
    chk("fin_a_red", int'(a_red), 24);
    chk("fin_a_busy", int'(a_busy), 1);

    // Asynchronous reset between clock edges in the middle of a fade-in
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a_red", int'(a_red), 0);
    chk("arst_a_green", int'(a_green), 0);
    chk("arst_a_blue", int'(a_blue), 0);
    chk("arst_a_en", int'(a_en), 0);
    chk("arst_a_busy", int'(a_busy), 0);
    chk("arst_b_en", int'(b_en), 0);
    ma = mreset(); mdb = mreset();
    @(negedge clk);
    rst_n = 1'b1;
    menu_r = 8'h12; menu_g = 8'h34; menu_b = 8'h56;
    tick();
    chk("post_rst_red", int'(a_red), 'h12);
    chk("post_rst_green", int'(a_green), 'h34);
    chk("post_rst_blue", int'(a_blue), 'h56);
    chk("post_rst_busy", int'(a_busy), 0);

`ifdef SCENE_FADE_SKIP_EN
    // Skip with ready jumps straight to the game without waiting for a frame
    start = 1'b1; tick();
    frame_pulse();
    ready = 1'b1; skip = 1'b1; tick();
    chk("skip_a_busy", int'(a_busy), 0);
    tick();
    chk("skip_a_red", int'(a_red), int'(game_r));
    skip = 1'b0; start = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
`endif

    // Randomised run against the model
    rand_pix = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      frame = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) start = ~start;
      if ($urandom_range(0, 19) == 0) ready = ~ready;
      if ($urandom_range(0, 9) == 0) skip = ~skip;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
